divider_result_buffer: RTL

// - Output stage of the pipelined restoring divider chain of divider_cell stages.
// - Captures the last stage's rdy/quotient/remainder/k tag into a DEPTH-entry FIFO.
// - Presents results on a valid/ready interface; the divider chain itself cannot stall.
// - Returns an issue credit upstream so the chain never holds more results than the FIFO can absorb.

---
 rtl/divider_result_buffer_if.sv | 31 +++
 rtl/divider_result_buffer.sv | 69 ++++++
 2 files changed

// File: rtl/divider_result_buffer_if.sv
// divider_result_buffer_if: issue credit, divider result input and valid/ready output bundle
interface divider_result_buffer_if #(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int DEPTH = 8,
    parameter int KW    = 4
);
    localparam int QW = N - M + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    logic          issue_valid;
    logic          issue_credit;
    logic          in_rdy;
    logic [QW-1:0] in_quotient;
    logic [M-1:0]  in_remainder;
    logic [KW-1:0] in_k;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] out_quotient;
    logic [M-1:0]  out_remainder;
    logic [KW-1:0] out_k;
    logic [CW-1:0] fifo_cnt;
    logic          overflow_err;
    modport slave (
        input  issue_valid, in_rdy, in_quotient, in_remainder, in_k, out_ready,
        output issue_credit, out_valid, out_quotient, out_remainder, out_k, fifo_cnt, overflow_err
    );
    modport master (
        output issue_valid, in_rdy, in_quotient, in_remainder, in_k, out_ready,
        input  issue_credit, out_valid, out_quotient, out_remainder, out_k, fifo_cnt, overflow_err
    );
endinterface

// File: rtl/divider_result_buffer.sv
// divider_result_buffer: credit-managed result FIFO for the divider chain (optional DIV_RESULT_BYPASS_EN)
module divider_result_buffer #(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int DEPTH = 8,
    parameter int KW    = 4
) (
    input logic clk,
    input logic rst,
    divider_result_buffer_if.slave rb_io
);
    localparam int QW = N - M + 1;
    localparam int DW = QW + M + KW;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d, infl_q, infl_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, bypass, pop, fifo_pop, push, inc, dec;
    logic [DW-1:0] in_data, head;
    // Datapath and handshake; the chain cannot stall, so a result with no room is dropped and flagged
    always_comb begin
        in_data = {rb_io.in_quotient, rb_io.in_remainder, rb_io.in_k};
        empty   = cnt_q == '0;
        full    = cnt_q == CW'(DEPTH);
`ifdef DIV_RESULT_BYPASS_EN
        bypass  = empty & rb_io.in_rdy;
`else
        bypass  = 1'b0;
`endif
        rb_io.out_valid = ~empty | bypass;
        head     = ~empty ? mem_q[rd_ptr_q] : (bypass ? in_data : '0);
        {rb_io.out_quotient, rb_io.out_remainder, rb_io.out_k} = head;
        pop      = rb_io.out_valid & rb_io.out_ready;
        fifo_pop = pop & ~empty;
        push     = rb_io.in_rdy & (~full | fifo_pop) & ~(bypass & rb_io.out_ready);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = fifo_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(fifo_pop);
        rb_io.issue_credit = ({1'b0, cnt_q} + {1'b0, infl_q}) < (CW + 1)'(DEPTH);
        inc      = rb_io.issue_valid & rb_io.issue_credit;
        dec      = rb_io.in_rdy & (inc | infl_q != '0);
        infl_d   = infl_q + CW'(inc) - CW'(dec);
        ovf_d    = ovf_q | (rb_io.in_rdy & full & ~fifo_pop);
        rb_io.fifo_cnt     = cnt_q;
        rb_io.overflow_err = ovf_q;
    end
    // Control state; reset discards everything queued or in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            infl_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            infl_q   <= infl_d;
            ovf_q    <= ovf_d;
        end
    end
    // Storage array; unreset because the head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end
endmodule
